// File: rtl/fetch_unit_pkg.sv
// Shared fetch-side definitions: machine width, reset vector, PC step and the
// {pc, instr} record that flows through the fetch FIFO.
package fetch_unit_pkg;
    localparam int          XLEN         = 32;
    localparam logic [31:0] INSTR_NOP    = 32'h0000_0013;
    localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] PC_STEP      = 32'd4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_unit_fifo.sv
// Small synchronous FIFO for fetched {pc, instr} records. Clear wins over push/pop;
// head data comes straight from registered storage.
module fetch_unit_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_clear,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic [CW-1:0]    o_count,
    output logic             o_full,
    output logic             o_empty
);
    logic [DEPTH-1:0][WIDTH-1:0] r_mem;
    logic [PW-1:0]               r_wptr;
    logic [PW-1:0]               r_rptr;
    logic [CW-1:0]               r_count;

    // Pointers wrap at DEPTH, so non-power-of-two depths work too.
    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem   <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wptr] <= i_wdata;
                r_wptr        <= nxt(r_wptr);
            end
            if (i_pop)
                r_rptr <= nxt(r_rptr);
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end

    assign o_rdata = r_mem[r_rptr];
    assign o_count = r_count;
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, credit-based issue to a 1-cycle synchronous imem,
// redirect flush, and a FIFO that keeps decode back-pressure off the address path.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_VECTOR,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_fetch_en,
    input  logic            i_redirect_valid,
    input  logic [XLEN-1:0] i_redirect_pc,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic [XLEN-1:0] i_imem_rdata,
    output logic            o_if_valid,
    input  logic            i_if_ready,
    output logic [XLEN-1:0] o_if_pc,
    output logic [XLEN-1:0] o_if_instr
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_inflight_pc;
    logic            r_inflight;

    logic [CW-1:0]   w_count;
    logic [CW:0]     w_occ;
    logic            w_full;
    logic            w_empty;
    logic            w_deq;
    logic            w_pop;
    logic            w_issue;
    logic [XLEN-1:0] w_redirect_tgt;
    fetch_entry_t    w_push_ent;
    fetch_entry_t    w_head;

    assign w_redirect_tgt = i_redirect_pc & ~32'h3;
    assign w_deq          = o_if_valid & i_if_ready;
    assign w_pop          = w_deq & ~i_redirect_valid;

    // Credit check counts the in-flight word, so a response always has a slot.
    assign w_occ   = {1'b0, w_count} + (CW + 1)'(r_inflight) - (CW + 1)'(w_deq);
    assign w_issue = i_fetch_en & ~i_redirect_valid & (w_occ < (CW + 1)'(FIFO_DEPTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc    <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
        end else if (i_redirect_valid) begin
            r_fetch_pc <= w_redirect_tgt;
            r_inflight <= 1'b0;
        end else if (w_issue) begin
            r_inflight    <= 1'b1;
            r_inflight_pc <= r_fetch_pc;
            r_fetch_pc    <= r_fetch_pc + PC_STEP;
        end else begin
            r_inflight <= 1'b0;
        end
    end

    assign w_push_ent.pc    = r_inflight_pc;
    assign w_push_ent.instr = i_imem_rdata;

    fetch_unit_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (r_inflight),
        .i_pop   (w_pop),
        .i_clear (i_redirect_valid),
        .i_wdata (w_push_ent),
        .o_rdata (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign o_imem_addr = r_fetch_pc;
    assign o_if_valid  = ~w_empty;
    assign o_if_pc     = w_head.pc;
    assign o_if_instr  = w_head.instr;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(r_inflight && w_full && !w_pop && !i_redirect_valid));
endmodule
